// File: rtl/ctrl_pipe_dec_if.sv
// Decode-to-pipeline control bus: the decode slot handshake, the per-stage
// stall/flush controls and the staged control bundles returned to the datapath.
interface ctrl_pipe_dec_if #(
    parameter int DEPTH = 3,
    parameter int CNTW  = 16,
    parameter int CW    = 12
);
    logic                  i_valid;
    logic [6:0]            i_opcode;
    logic [DEPTH-1:0]      i_stall;
    logic [DEPTH-1:0]      i_flush;
    logic                  i_cnt_clr;
    logic                  o_ready;
    logic [DEPTH-1:0]      o_valid;
    logic [DEPTH*CW-1:0]   o_ctrl;
    logic [CNTW-1:0]       o_illegal_cnt;

    // Driver side: decode stage plus pipeline hazard control
    modport master (
        output i_valid, i_opcode, i_stall, i_flush, i_cnt_clr,
        input  o_ready, o_valid, o_ctrl, o_illegal_cnt
    );

    // Receiver side: the control pipeline itself
    modport slave (
        input  i_valid, i_opcode, i_stall, i_flush, i_cnt_clr,
        output o_ready, o_valid, o_ctrl, o_illegal_cnt
    );
endinterface

// File: rtl/ctrl_pipe_dec.sv
// RV32I main decoder feeding a DEPTH-stage control pipeline (E, M, W, ...).
// Each stage has its own valid bit, stall and flush; a stall in any stage
// holds every earlier stage, and a stage whose predecessor is held takes a
// bubble. Illegal instructions that retire from the last stage are counted
// in a saturating counter.
module ctrl_pipe_dec #(
    parameter int DEPTH = 3,
    parameter int CNTW  = 16,
    parameter int CW    = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    ctrl_pipe_dec_if.slave bus
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_UPC = 7'b0010111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam int BIT_ILLEGAL = 11;

    // Bundle layout, LSB first: regwrite, sel1, sel2, load, store, branch,
    // jal, jalr, resultsrc[1:0], lui, illegal. Illegal opcodes keep the
    // operand selects at their rs1/imm defaults but drive no side effects.
    function automatic logic [CW-1:0] decode(input logic [6:0] op);
        logic       rw, s1, s2, ld, st, br, jl, jr, lu, ill;
        logic [1:0] rs;
        rw = 1'b0; s1 = 1'b1; s2 = 1'b1; ld = 1'b0; st = 1'b0;
        br = 1'b0; jl = 1'b0; jr = 1'b0; lu = 1'b0; ill = 1'b0;
        rs = 2'b00;
        case (op)
            OP_R:   begin rw = 1'b1; s2 = 1'b0; end
            OP_I:   rw = 1'b1;
            OP_LD:  begin rw = 1'b1; ld = 1'b1; rs = 2'b01; end
            OP_S:   st = 1'b1;
            OP_B:   begin s1 = 1'b0; br = 1'b1; end
            OP_J:   begin rw = 1'b1; s1 = 1'b0; jl = 1'b1; rs = 2'b10; end
            OP_JR:  begin rw = 1'b1; jr = 1'b1; rs = 2'b10; end
            OP_LUI: begin rw = 1'b1; lu = 1'b1; end
            OP_UPC: begin rw = 1'b1; s1 = 1'b0; end
            OP_SYS: ;
            default: ill = 1'b1;
        endcase
        return {ill, lu, rs, jr, jl, br, st, ld, s2, s1, rw};
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    logic              vld_p [DEPTH];
    logic [CW-1:0]     ctl_p [DEPTH];
    logic [DEPTH-1:0]  hold;
    logic [CW-1:0]     dec_ctl;
    logic              retire_ill;
    logic [CNTW-1:0]   ill_cnt;

    // An empty decode slot feeds an all-zero bundle so invalid stages read 0.
    assign dec_ctl = bus.i_valid ? decode(bus.i_opcode) : '0;

    // Backward hold chain: a stage holds if it or any later stage stalls.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc     = acc | bus.i_stall[k];
            hold[k] = acc;
        end
    end

    assign bus.o_ready = ~hold[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Stage 0 (E): flush beats hold, otherwise capture the decode slot.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_p[k] <= 1'b0;
                    ctl_p[k] <= '0;
                end else if (bus.i_flush[k]) begin
                    vld_p[k] <= 1'b0;
                    ctl_p[k] <= '0;
                end else if (!hold[k]) begin
                    vld_p[k] <= bus.i_valid;
                    ctl_p[k] <= dec_ctl;
                end
            end
        end else begin : g_next
            // Stage k: flush beats hold; a held predecessor leaves a bubble.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_p[k] <= 1'b0;
                    ctl_p[k] <= '0;
                end else if (bus.i_flush[k]) begin
                    vld_p[k] <= 1'b0;
                    ctl_p[k] <= '0;
                end else if (!hold[k]) begin
                    if (hold[k-1]) begin
                        vld_p[k] <= 1'b0;
                        ctl_p[k] <= '0;
                    end else begin
                        vld_p[k] <= vld_p[k-1];
                        ctl_p[k] <= ctl_p[k-1];
                    end
                end
            end
        end

        assign bus.o_valid[k]          = vld_p[k];
        assign bus.o_ctrl[k*CW +: CW]  = ctl_p[k];
    end

    // An instruction retires when the last stage is valid and neither held nor killed.
    assign retire_ill = vld_p[DEPTH-1] & ~bus.i_stall[DEPTH-1] & ~bus.i_flush[DEPTH-1]
                      & ctl_p[DEPTH-1][BIT_ILLEGAL];

    // Illegal-retire counter: clear wins over a simultaneous increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (bus.i_cnt_clr) begin
            ill_cnt <= '0;
        end else if (retire_ill) begin
            ill_cnt <= sat_inc(ill_cnt);
        end
    end

    assign bus.o_illegal_cnt = ill_cnt;

endmodule
